shared_resource_port: RTL and testbench
=======================================

Name: shared_resource_port

Overview:
- Downstream stage of shared_resource_arbiter. Consumes its one-hot grant vector and the per-client command streams.
- Forwards the granted client's multi-beat burst onto the single shared-resource bus through a registered output stage.
- Ownership is locked from the first accepted beat until the last beat, so a grant change mid-burst cannot interleave clients.
- Reports burst completion per client, and flags truncated bursts and malformed grants.

Parameters:
- N, 8, number of clients; must match the arbiter's N.
- DW, 32, data width per beat.
- MAX_BURST, 16, maximum beats per burst; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- grant  in  N  one-hot grant from the arbiter; all-zero means no grant.
- cmd_valid  in  N  per-client beat valid.
- cmd_data  in  N*DW  flattened payloads; client i occupies bits [i*DW +: DW].
- cmd_last  in  N  per-client last-beat flag.
- cmd_ready  out  N  per-client beat accept.
- res_valid  out  1  resource-bus beat valid.
- res_data  out  DW  resource-bus payload.
- res_last  out  1  resource-bus last beat of burst.
- res_owner  out  clog2(N)  index of the client that owns res_data.
- res_ready  in  1  resource backpressure.
- done  out  N  one-cycle pulse on the owner's bit when its burst completes.
- busy  out  1  high while in state BUSY.
- trunc_err  out  1  one-cycle pulse when a burst is force-ended at MAX_BURST.
- grant_err  out  1  one-cycle pulse when grant is not zero or one-hot.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, owner=0, beat_cnt=0. Every output is 0: res_valid, res_data, res_last, res_owner, done, busy, trunc_err, grant_err. cmd_ready is 0 combinationally.
- Registers: beat_cnt is clog2(MAX_BURST+1) bits wide. owner is clog2(N) bits wide.
- Selection:
  - In IDLE: sel = encoded index of grant; sel_ok = grant is exactly one-hot.
  - In BUSY: sel = owner; sel_ok = 1; grant is ignored.
- Space: space = !res_valid || res_ready.
- cmd_ready[i] = sel_ok && (i==sel) && space. All other bits are 0. cmd_ready is combinational.
- Accept: acc = cmd_valid[sel] && cmd_ready[sel]. On acc:
  - res_data <= cmd_data[sel]; res_owner <= sel; res_valid <= 1.
  - eff_last = cmd_last[sel] || (beat_cnt == MAX_BURST-1); res_last <= eff_last.
  - Latency: exactly 1 cycle from accept to res_valid.
- If there is no acc and res_valid && res_ready: res_valid <= 0 and res_last <= 0. res_data holds its value.
- FSM:
  - IDLE --acc && !eff_last--> BUSY. owner <= sel; beat_cnt <= 1.
  - IDLE --acc && eff_last--> IDLE. This is a single-beat burst; done[sel] pulses.
  - BUSY --acc && !eff_last--> BUSY. beat_cnt increments.
  - BUSY --acc && eff_last--> IDLE. beat_cnt <= 0.
  - BUSY with no acc: stay in BUSY, even if grant drops or moves.
- done[sel] is registered. It pulses in the same cycle res_last first goes high for that beat.
- trunc_err pulses with done when eff_last is set by the counter while cmd_last[sel]=0. The client's next beat is treated as a new burst and needs a new grant.
- busy = (state==BUSY), registered with the state.
- grant_err pulses the cycle after a non-zero, non-one-hot grant is sampled in IDLE. No beat is accepted in that cycle. In BUSY, grant is not checked.
- Simultaneous events:
  - Output drain and a new accept in the same cycle overwrite the register. There is no bubble, so throughput is 1 beat/cycle when res_ready=1.
  - Holding res_ready=0 stalls all clients via cmd_ready=0. res_data/res_last/res_owner must stay stable while res_valid=1 and res_ready=0.
- Reset mid-burst: returns to IDLE immediately. The in-flight res beat is discarded and no done is pulsed.
- MAX_BURST=1: every accepted beat is last. trunc_err fires whenever cmd_last=0.

Test Plan:
- Reset then idle: with grant=0 and cmd_valid=8'hFF, cmd_ready stays 0, res_valid stays 0 and busy stays 0 for 5 cycles.
- Single client, 3-beat burst: grant=8'h01, client 0 sends D0..D2 with last on D2, res_ready=1. Required: res_data=D0,D1,D2 on consecutive cycles, each 1 cycle after its accept; res_owner=0; res_last only with D2; done=8'h01 once; busy high for 2 cycles.
- Grant moves mid-burst: client 1 is BUSY after beat 1 of 4 and grant switches to 8'h08. Required: cmd_ready[3]=0 until client 1's last beat. Then, with grant still 8'h08, client 3 is accepted the next cycle.
- Backpressure: res_ready=0 for 3 cycles during a burst. Required: res_data held; cmd_ready all 0 for those cycles; no beat lost or duplicated after release.
- Truncation: MAX_BURST=16, client 7 streams 20 beats with no last. Required: beat 16 carries res_last=1; trunc_err and done[7] pulse together; beats 17–20 form a new burst after re-grant.
- Bad grant and reset: grant=8'h03 in IDLE gives grant_err=1 one cycle later and no accept. Asserting rst_n=0 mid-burst clears res_valid and busy asynchronously, with no done pulse.

Source files
------------

// File: rtl/shared_resource_port.sv
// Shared-resource output port: forwards the granted client's burst onto one
// registered resource bus, locking ownership for the whole burst.
module shared_resource_port #(
    parameter int unsigned N         = 8,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned OW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    grant,
    input  logic [N-1:0]    cmd_valid,
    input  logic [N*DW-1:0] cmd_data,
    input  logic [N-1:0]    cmd_last,
    output logic [N-1:0]    cmd_ready,
    output logic            res_valid,
    output logic [DW-1:0]   res_data,
    output logic            res_last,
    output logic [OW-1:0]   res_owner,
    input  logic            res_ready,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic            trunc_err,
    output logic            grant_err
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_d;
    logic [OW-1:0]   owner, owner_d;
    logic [CW-1:0]   beat_cnt, beat_cnt_d;

    logic [OW-1:0]   grant_idx;
    logic            grant_onehot;
    logic [OW-1:0]   sel;
    logic            sel_ok, space, acc, eff_last;
    logic            sel_valid, sel_last;
    logic [DW-1:0]   sel_data;

    logic            res_valid_d, res_last_d, trunc_err_d, grant_err_d;
    logic [DW-1:0]   res_data_d;
    logic [OW-1:0]   res_owner_d;
    logic [N-1:0]    done_d;

    // Grant encoder and one-hot qualification
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_idx = OW'(i);
        end
        grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
    end

    // Next-state, ready generation and output-stage update
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        beat_cnt_d  = beat_cnt;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_last_d  = res_last;
        res_owner_d = res_owner;
        done_d      = '0;
        trunc_err_d = 1'b0;
        grant_err_d = 1'b0;
        cmd_ready   = '0;
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_data    = '0;

        sel    = (state == BUSY) ? owner : grant_idx;
        sel_ok = (state == BUSY) || grant_onehot;
        space  = !res_valid || res_ready;

        for (int i = 0; i < N; i++) begin
            if (OW'(i) == sel) begin
                cmd_ready[i] = sel_ok && space && rst_n;
                sel_valid    = cmd_valid[i];
                sel_last     = cmd_last[i];
                sel_data     = cmd_data[i*DW +: DW];
            end
        end

        acc      = sel_valid && sel_ok && space && rst_n;
        eff_last = sel_last || (beat_cnt == CW'(MAX_BURST - 1));

        if (acc) begin
            res_valid_d = 1'b1;
            res_data_d  = sel_data;
            res_owner_d = sel;
            res_last_d  = eff_last;
            if (eff_last) begin
                done_d      = N'(1) << sel;
                trunc_err_d = !sel_last;
                state_d     = IDLE;
                beat_cnt_d  = '0;
            end else begin
                state_d = BUSY;
                if (state == IDLE) begin
                    owner_d    = sel;
                    beat_cnt_d = CW'(1);
                end else begin
                    beat_cnt_d = beat_cnt + CW'(1);
                end
            end
        end else if (res_valid && res_ready) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
        end

        if ((state == IDLE) && (grant != '0) && !grant_onehot) grant_err_d = 1'b1;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            beat_cnt  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
            res_owner <= '0;
            done      <= '0;
            busy      <= 1'b0;
            trunc_err <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            beat_cnt  <= beat_cnt_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_last  <= res_last_d;
            res_owner <= res_owner_d;
            done      <= done_d;
            busy      <= (state_d == BUSY);
            trunc_err <= trunc_err_d;
            grant_err <= grant_err_d;
        end
    end

endmodule

// File: tb/tb_shared_resource_port.sv
// Bench for shared_resource_port: idle/grant vector table, hand-written burst
// sequences, and a queue scoreboard checking every resource-bus transfer.
module tb_shared_resource_port;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 16;
    localparam int unsigned OW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    grant, cmd_valid, cmd_last, cmd_ready, done;
    logic [N*DW-1:0] cmd_data;
    logic            res_valid, res_last, res_ready, busy, trunc_err, grant_err;
    logic [DW-1:0]   res_data;
    logic [OW-1:0]   res_owner;

    always #5 clk = ~clk;

    shared_resource_port #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .grant(grant), .cmd_valid(cmd_valid),
        .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .res_owner(res_owner), .res_ready(res_ready), .done(done), .busy(busy),
        .trunc_err(trunc_err), .grant_err(grant_err)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [OW-1:0] owner;
        logic          last;
    } beat_t;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] valid;
        logic [N-1:0] exp_rdy;
        logic         exp_gerr;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[10];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        grant     = '0;
        cmd_valid = '0;
        cmd_last  = '0;
        tick();
    endtask

    // Drive one beat from client c (plus extra valids); expect cmd_ready == exp_rdy
    task automatic send(input logic [N-1:0] g, input logic [N-1:0] extra, input int c,
                        input logic [DW-1:0] d, input logic l,
                        input logic [N-1:0] exp_rdy, input logic exp_last);
        beat_t b;
        grant              = g;
        cmd_valid          = extra;
        cmd_valid[c]       = 1'b1;
        cmd_last           = '0;
        cmd_last[c]        = l;
        cmd_data[c*DW +: DW] = d;
        #2;
        check("cmd_ready", 64'(cmd_ready), 64'(exp_rdy));
        if (exp_rdy[c]) begin
            b.data  = d;
            b.owner = OW'(c);
            b.last  = exp_last;
            sb.push_back(b);
        end
        tick();
        if (exp_rdy[c]) begin
            check("accept_res_valid", 64'(res_valid), 64'(1));
            check("accept_res_data", 64'(res_data), 64'(d));
            check("accept_res_last", 64'(res_last), 64'(exp_last));
        end
    endtask

    // Scoreboard: every transfer on the resource bus must match the next expected beat
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && res_valid && res_ready) begin
            check("beat_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("res_beat", 64'({res_data, res_owner, res_last}), 64'(e));
            end
        end
    end

    initial begin
        vecs[0] = '{8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 1'b0};
        vecs[2] = '{8'h03, 8'hFF, 8'h00, 1'b1};
        vecs[3] = '{8'h81, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b1};
        vecs[5] = '{8'h01, 8'h00, 8'h01, 1'b0};
        vecs[6] = '{8'h80, 8'h00, 8'h80, 1'b0};
        vecs[7] = '{8'h10, 8'h00, 8'h10, 1'b0};
        vecs[8] = '{8'h04, 8'hFB, 8'h04, 1'b0};
        vecs[9] = '{8'h0C, 8'h00, 8'h00, 1'b1};

        // Reset state, with a valid one-hot grant pending
        rst_n     = 1'b0;
        grant     = 8'h01;
        cmd_valid = 8'hFF;
        cmd_last  = '0;
        cmd_data  = '0;
        res_ready = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_res_last", 64'(res_last), 64'(0));
        check("rst_res_owner", 64'(res_owner), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_trunc_err", 64'(trunc_err), 64'(0));
        check("rst_grant_err", 64'(grant_err), 64'(0));
        grant = '0;
        rst_n = 1'b1;
        tick();

        // Idle vectors: ready decode, no accept, grant_err one cycle later
        for (int i = 0; i < 10; i++) begin
            grant     = vecs[i].grant;
            cmd_valid = vecs[i].valid;
            cmd_last  = '0;
            #2;
            check("vec_cmd_ready", 64'(cmd_ready), 64'(vecs[i].exp_rdy));
            tick();
            check("vec_grant_err", 64'(grant_err), 64'(vecs[i].exp_gerr));
            check("vec_res_valid", 64'(res_valid), 64'(0));
            check("vec_busy", 64'(busy), 64'(0));
        end
        quiet();
        check("gerr_clear", 64'(grant_err), 64'(0));

        // 3-beat burst from client 0; a bad grant while BUSY is ignored
        send(8'h01, 8'h00, 0, 32'hA000_0000, 1'b0, 8'h01, 1'b0);
        check("a_busy0", 64'(busy), 64'(1));
        check("a_owner", 64'(res_owner), 64'(0));
        send(8'h03, 8'h00, 0, 32'hA000_0001, 1'b0, 8'h01, 1'b0);
        check("a_busy1", 64'(busy), 64'(1));
        check("a_no_gerr_busy", 64'(grant_err), 64'(0));
        check("a_done_mid", 64'(done), 64'(0));
        send(8'h01, 8'h00, 0, 32'hA000_0002, 1'b1, 8'h01, 1'b1);
        check("a_done", 64'(done), 64'(8'h01));
        check("a_busy_end", 64'(busy), 64'(0));
        quiet();
        check("a_done_pulse", 64'(done), 64'(0));
        check("a_drained", 64'(res_valid), 64'(0));

        // Grant moves to client 3 while client 1 owns a 4-beat burst
        send(8'h02, 8'h00, 1, 32'hB000_0000, 1'b0, 8'h02, 1'b0);
        send(8'h08, 8'h08, 1, 32'hB000_0001, 1'b0, 8'h02, 1'b0);
        send(8'h08, 8'h08, 1, 32'hB000_0002, 1'b0, 8'h02, 1'b0);
        send(8'h08, 8'h08, 1, 32'hB000_0003, 1'b1, 8'h02, 1'b1);
        check("b_done1", 64'(done), 64'(8'h02));
        send(8'h08, 8'h00, 3, 32'hC000_0000, 1'b1, 8'h08, 1'b1);
        check("b_done3", 64'(done), 64'(8'h08));
        check("b_owner3", 64'(res_owner), 64'(3));
        quiet();

        // Backpressure: three stalled cycles mid-burst
        send(8'h04, 8'h00, 2, 32'hE000_0000, 1'b0, 8'h04, 1'b0);
        res_ready = 1'b0;
        cmd_valid = 8'h04;
        cmd_data[2*DW +: DW] = 32'hE000_0001;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("c_stall_ready", 64'(cmd_ready), 64'(0));
            check("c_stall_valid", 64'(res_valid), 64'(1));
            check("c_stall_data", 64'(res_data), 64'(32'hE000_0000));
            check("c_stall_owner", 64'(res_owner), 64'(2));
            tick();
        end
        res_ready = 1'b1;
        send(8'h04, 8'h00, 2, 32'hE000_0001, 1'b0, 8'h04, 1'b0);
        send(8'h04, 8'h00, 2, 32'hE000_0002, 1'b0, 8'h04, 1'b0);
        send(8'h04, 8'h00, 2, 32'hE000_0003, 1'b1, 8'h04, 1'b1);
        check("c_done", 64'(done), 64'(8'h04));
        quiet();

        // Truncation at MAX_BURST: client 7 streams 20 beats without last
        for (int k = 1; k <= 20; k++) begin
            send(8'h80, 8'h00, 7, 32'hD700_0000 + 32'(k), 1'b0, 8'h80, (k == 16));
            check("d_trunc_err", 64'(trunc_err), 64'(k == 16));
            check("d_done", 64'(done), (k == 16) ? 64'h80 : 64'h0);
            check("d_busy", 64'(busy), 64'(k != 16));
        end
        send(8'h80, 8'h00, 7, 32'hD700_00FF, 1'b1, 8'h80, 1'b1);
        check("d_done_close", 64'(done), 64'(8'h80));
        check("d_no_trunc", 64'(trunc_err), 64'(0));
        quiet();

        // Reset mid-burst with a beat held on the bus
        send(8'h20, 8'h00, 5, 32'hF000_0000, 1'b0, 8'h20, 1'b0);
        res_ready = 1'b0;
        cmd_valid = 8'h20;
        cmd_data[5*DW +: DW] = 32'hF000_0001;
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_valid", 64'(res_valid), 64'(0));
        check("e_rst_busy", 64'(busy), 64'(0));
        check("e_rst_ready", 64'(cmd_ready), 64'(0));
        check("e_rst_done", 64'(done), 64'(0));
        sb.delete();
        tick();
        check("e_rst_done2", 64'(done), 64'(0));
        grant     = '0;
        cmd_valid = '0;
        res_ready = 1'b1;
        rst_n     = 1'b1;
        tick();
        check("e_post_busy", 64'(busy), 64'(0));
        check("e_post_valid", 64'(res_valid), 64'(0));
        send(8'h10, 8'h00, 4, 32'h4444_0000, 1'b1, 8'h10, 1'b1);
        check("e_post_done", 64'(done), 64'(8'h10));
        quiet();
        quiet();

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
